// File: rtl/xadc_drp_scanner.sv
// xadc_drp_scanner: on each XADC eoc, reads the enabled aux result registers over DRP, ascending ch0..3.
// Latency: eoc_in -> drp_den next cycle; drp_drdy -> smp_valid next cycle.
// Backpressure: a result is held until smp_ready; no further DRP read is issued while it waits.
// Option XADC_SCAN_AVG_EN: emit the truncated mean of every four successful reads per channel.
module xadc_drp_scanner #(
    parameter logic [6:0] ADDR_CH0    = 7'h1E,
    parameter logic [6:0] ADDR_CH1    = 7'h17,
    parameter logic [6:0] ADDR_CH2    = 7'h1F,
    parameter logic [6:0] ADDR_CH3    = 7'h16,
    parameter int         TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ch_en,
    input  logic        eoc_in,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic [11:0] smp_data,
    output logic [1:0]  smp_ch,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic        overrun,
    output logic        timeout,
    input  logic        clr_flags
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_NEXT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_en;
    logic [1:0]    r_ch;
    logic [TW-1:0] r_tcnt;
    logic [11:0]   r_data;
    logic          r_overrun;
    logic          r_timeout;

    logic          w_start;
    logic          w_drdy_hit;
    logic          w_tout;
    logic          w_emit;
    logic          w_more;
    logic [3:0]    w_above;
    logic [1:0]    w_first_ch;
    logic [1:0]    w_next_ch;
    logic [11:0]   w_result;
    logic          w_den;
    logic          w_vld;
    logic [6:0]    w_daddr;
    logic          w_unused_do;

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign w_start     = (r_state == S_IDLE) && eoc_in && (|ch_en);
    assign w_drdy_hit  = (r_state == S_WAIT) && drp_drdy;
    assign w_tout      = (r_state == S_WAIT) && !drp_drdy && (r_tcnt == TW'(TIMEOUT_CYC - 1));
    assign w_above     = r_en & (4'b1110 << r_ch);
    assign w_more      = |w_above;
    assign w_next_ch   = lowest_set(w_above);
    assign w_first_ch  = lowest_set(ch_en);
    assign w_unused_do = ^drp_do[3:0];

`ifdef XADC_SCAN_AVG_EN
    logic [13:0] r_acc [4];
    logic [1:0]  r_cnt [4];
    logic [13:0] w_sum;

    assign w_sum    = r_acc[r_ch] + {2'b00, drp_do[15:4]};
    assign w_emit   = (r_cnt[r_ch] == 2'd3);
    assign w_result = w_sum[13:2];

    // Accumulate each successful read; the channel restarts from zero once its mean is emitted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (w_drdy_hit) begin
            if (w_emit) begin
                r_acc[r_ch] <= '0;
                r_cnt[r_ch] <= '0;
            end else begin
                r_acc[r_ch] <= w_sum;
                r_cnt[r_ch] <= r_cnt[r_ch] + 2'd1;
            end
        end
    end
`else
    assign w_emit   = 1'b1;
    assign w_result = drp_do[15:4];
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state plus the strobes that follow directly from the state.
    always_comb begin
        w_state_nxt = r_state;
        w_den       = 1'b0;
        w_vld       = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_REQ;
            S_REQ: begin
                w_den       = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (drp_drdy)    w_state_nxt = w_emit ? S_OUT : S_NEXT;
                else if (w_tout) w_state_nxt = S_NEXT;
            end
            S_OUT: begin
                w_vld = 1'b1;
                if (smp_ready) w_state_nxt = S_NEXT;
            end
            S_NEXT:  w_state_nxt = w_more ? S_REQ : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sweep context: enabled set frozen at sweep start, current channel, drdy wait counter, result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en   <= '0;
            r_ch   <= '0;
            r_tcnt <= '0;
            r_data <= '0;
        end else begin
            if (w_start) begin
                r_en <= ch_en;
                r_ch <= w_first_ch;
            end else if ((r_state == S_NEXT) && w_more) begin
                r_ch <= w_next_ch;
            end
            if (r_state == S_REQ)       r_tcnt <= '0;
            else if (r_state == S_WAIT) r_tcnt <= r_tcnt + TW'(1);
            if (w_drdy_hit && w_emit)   r_data <= w_result;
        end
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_overrun <= (r_overrun & ~clr_flags) | (eoc_in && (r_state != S_IDLE));
            r_timeout <= (r_timeout & ~clr_flags) | w_tout;
        end
    end

    // Result register address of the current channel.
    always_comb begin
        w_daddr = ADDR_CH0;
        case (r_ch)
            2'd0:    w_daddr = ADDR_CH0;
            2'd1:    w_daddr = ADDR_CH1;
            2'd2:    w_daddr = ADDR_CH2;
            default: w_daddr = ADDR_CH3;
        endcase
    end

    assign drp_daddr = w_daddr;
    assign drp_den   = w_den;
    assign drp_dwe   = 1'b0;
    assign drp_di    = 16'h0000;
    assign smp_data  = r_data;
    assign smp_ch    = r_ch;
    assign smp_valid = w_vld;
    assign overrun   = r_overrun;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_xadc_drp_scanner.sv
// Bench for xadc_drp_scanner: directed scenarios then randomized sweeps against a queue-based model.
// The DRP slave and the stream sink are modelled here; all expectations come from ch_en and drp_do.
// Define XADC_SCAN_AVG_EN for both files to exercise the averaging build.
module tb_xadc_drp_scanner;
    localparam logic [6:0] A0 = 7'h1E, A1 = 7'h17, A2 = 7'h1F, A3 = 7'h16;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n, eoc_in, drp_den, drp_dwe, drp_drdy, smp_valid, smp_ready;
    logic        overrun, timeout, clr_flags;
    logic [3:0]  ch_en;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di, drp_do;
    logic [11:0] smp_data;
    logic [1:0]  smp_ch;

    xadc_drp_scanner dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .eoc_in(eoc_in),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy), .smp_data(smp_data), .smp_ch(smp_ch),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .overrun(overrun), .timeout(timeout),
        .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [6:0]  addr_q[$];
    logic [13:0] res_q[$];
    int          sum[4];
    int          nrd[4];
    bit          pend = 0;
    int          pcnt = 0;
    logic [15:0] pdata = '0;
    logic [1:0]  pch = '0;
    int          resp_mode = 2;
    int          resp_delay = 0;
    logic [15:0] resp_fixed = '0;
    bit          abandon = 0;
    bit          hold_ready = 0;
    bit          rand_ready = 0;
    int          n_out = 0;
    logic [13:0] last_out = '0;

    function automatic logic [6:0] addr_of(input int i);
        case (i)
            0: return A0;
            1: return A1;
            2: return A2;
            default: return A3;
        endcase
    endfunction

    function automatic logic [1:0] ch_of(input logic [6:0] a);
        case (a)
            A0: return 2'd0;
            A1: return 2'd1;
            A2: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // DRP slave: answers each den after a delay; every answered read feeds the expected-result model.
    always @(negedge clk) begin
        drp_drdy = 1'b0;
        if (pend) begin
            if (pcnt <= 1) begin
                drp_drdy = 1'b1;
                drp_do   = pdata;
                pend     = 0;
                if (abandon) abandon = 0;
                else begin
`ifdef XADC_SCAN_AVG_EN
                    sum[pch] += int'(pdata[15:4]);
                    nrd[pch]++;
                    if (nrd[pch] == 4) begin
                        res_q.push_back({pch, 12'(sum[pch] / 4)});
                        sum[pch] = 0;
                        nrd[pch] = 0;
                    end
`else
                    res_q.push_back({pch, pdata[15:4]});
`endif
                end
            end else pcnt--;
        end
        if (drp_den === 1'b1) begin
            chk("den_expected", addr_q.size() != 0, 1);
            if (addr_q.size() != 0) chk("den_addr", drp_daddr, addr_q.pop_front());
            if (resp_mode != 0) begin
                pend  = 1;
                pcnt  = (resp_delay == 0) ? int'($urandom_range(1, 6)) : resp_delay;
                pdata = (resp_mode == 1) ? resp_fixed : 16'($urandom);
                pch   = ch_of(drp_daddr);
            end
        end
    end

    // Stream sink: drives ready, checks hold stability and each accepted result against the model.
    logic        m_v, m_r, pv = 0, phs = 0;
    logic [13:0] phold = '0;
    always @(negedge clk) begin
        m_v = smp_valid;
        if (pv && !phs && rst_n) chk("hold", {m_v, smp_ch, smp_data}, {1'b1, phold});
        m_r = hold_ready ? 1'b0 : (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
        smp_ready = m_r;
        if (m_v && m_r) begin
            chk("result_expected", res_q.size() != 0, 1);
            if (res_q.size() != 0) chk("result", {smp_ch, smp_data}, res_q.pop_front());
            n_out++;
            last_out = {smp_ch, smp_data};
        end
        pv    = m_v && rst_n;
        phs   = m_v && m_r;
        phold = {smp_ch, smp_data};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // eoc while the scanner is idle: the model expects one read per enabled channel, ascending.
    task automatic start_sweep(input logic [3:0] en);
        ch_en = en;
        for (int i = 0; i < 4; i++) if (en[i]) addr_q.push_back(addr_of(i));
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
    endtask

    task automatic stray_eoc();
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        while (!(addr_q.size() == 0 && !pend && res_q.size() == 0 && !smp_valid) && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_quiet"}, n < 3000, 1);
        if (n >= 3000) begin
            addr_q.delete();
            res_q.delete();
        end
        repeat (3) tick();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!smp_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_valid_seen"}, smp_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_den"}, drp_den, 0);
        chk({tag, "_daddr"}, drp_daddr, A0);
        chk({tag, "_valid"}, smp_valid, 0);
        chk({tag, "_data"}, smp_data, 0);
        chk({tag, "_ch"}, smp_ch, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n, inj;
        logic [3:0]  en;
        logic [11:0] held;
        for (int i = 0; i < 4; i++) begin
            sum[i] = 0;
            nrd[i] = 0;
        end
        rst_n = 1'b0; eoc_in = 1'b0; ch_en = 4'h0; clr_flags = 1'b0;
        drp_drdy = 1'b0; drp_do = 16'h0; smp_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        chk("rst_dwe", drp_dwe, 0);
        chk("rst_di", drp_di, 0);
        rst_n = 1'b1;
        tick();

`ifndef XADC_SCAN_AVG_EN
        // 1: single channel, fixed data, drdy three cycles after den
        resp_mode = 1; resp_fixed = 16'hABC0; resp_delay = 3;
        ch_en = 4'b0001;
        chk("t1_den_before", drp_den, 0);
        start_sweep(4'b0001);
        chk("t1_den", drp_den, 1);
        chk("t1_daddr", drp_daddr, A0);
        wait_valid("t1");
        chk("t1_data", smp_data, 12'hABC);
        chk("t1_ch", smp_ch, 0);
        wait_quiet("t1");

        // 2: channels 1 and 3 in one sweep
        resp_mode = 2; resp_delay = 0;
        n0 = n_out;
        start_sweep(4'b1010);
        wait_quiet("t2");
        chk("t2_count", n_out - n0, 2);

        // 3: downstream stall holds the result and blocks the next read
        hold_ready = 1;
        start_sweep(4'b0011);
        wait_valid("t3");
        held = smp_data;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t3_valid_held", smp_valid, 1);
            chk("t3_data_held", smp_data, held);
            chk("t3_no_den", drp_den, 0);
        end
        hold_ready = 0;
        n = 0;
        while (!drp_den && n < 10) begin
            tick();
            n++;
        end
        chk("t3_den_after_release", drp_den, 1);
        wait_quiet("t3");

        // 4: missing drdy times out, no sample, scanner returns to idle
        resp_mode = 0;
        start_sweep(4'b0001);
        chk("t4_timeout_early", timeout, 0);
        n = 0;
        while (!timeout && n < 200) begin
            tick();
            n++;
        end
        chk("t4_timeout_latency", n, TO + 1);
        repeat (3) tick();
        chk("t4_no_valid", smp_valid, 0);
        clr_pulse();
        chk("t4_timeout_cleared", timeout, 0);
        resp_mode = 2; resp_delay = 2;
        start_sweep(4'b0100);
        chk("t4_idle_again_den", drp_den, 1);
        wait_quiet("t4");
        chk("t4_no_overrun", overrun, 0);

        // 5: eoc during a sweep flags overrun; set beats clear; ch_en change is deferred
        resp_delay = 8;
        n0 = n_out;
        start_sweep(4'b0011);
        ch_en = 4'b1111;
        tick();
        stray_eoc();
        chk("t5_overrun", overrun, 1);
        eoc_in = 1'b1; clr_flags = 1'b1;
        tick();
        eoc_in = 1'b0; clr_flags = 1'b0;
        chk("t5_set_beats_clear", overrun, 1);
        wait_quiet("t5");
        chk("t5_overrun_sticky", overrun, 1);
        chk("t5_count", n_out - n0, 2);
        clr_pulse();
        chk("t5_overrun_cleared", overrun, 0);

        // 5b: reset in WAIT aborts; the late drdy is ignored
        resp_delay = 10;
        start_sweep(4'b0001);
        stray_eoc();
        chk("t5b_overrun", overrun, 1);
        rst_n = 1'b0; abandon = 1;
        tick();
        check_reset_outputs("t5b_rst");
        rst_n = 1'b1;
        repeat (15) tick();
        chk("t5b_no_valid", smp_valid, 0);

        // eoc with nothing enabled is ignored silently
        start_sweep(4'b0000);
        repeat (4) tick();
        chk("zero_en_overrun", overrun, 0);
        chk("zero_en_den", drp_den, 0);
`else
        // 6: four ch0 sweeps produce one averaged result
        resp_mode = 1; resp_delay = 2;
        for (int k = 1; k <= 4; k++) begin
            n0 = n_out;
            resp_fixed = 16'(k * 16'h1000);
            start_sweep(4'b0001);
            wait_quiet("t6");
            chk("t6_count", n_out - n0, (k == 4) ? 1 : 0);
        end
        chk("t6_avg", last_out, {2'd0, 12'h280});
`endif

        // Randomized sweeps: random enables, data, latencies, ready, occasional overrun
        resp_mode = 2; resp_delay = 0; rand_ready = 1;
        for (int it = 0; it < 40; it++) begin
            en  = 4'($urandom_range(0, 15));
            inj = (en != 0) && ($urandom_range(0, 3) == 0);
            start_sweep(en);
            ch_en = 4'($urandom);
            if (inj != 0) begin
                if ($urandom_range(0, 1) == 1) tick();
                stray_eoc();
            end
            wait_quiet("rnd");
            chk("rnd_overrun", overrun, inj);
            chk("rnd_timeout", timeout, 0);
            if (overrun) clr_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
